// File: rtl/tb_inst_encoder.sv
// ---------------------------------------------------------------------------
// tb_inst_encoder
//   Bench-side RV32IM instruction encoder and instruction-image writer.
//   Symbolic requests (class, funct ordinal, registers, immediate) are packed
//   into 32-bit RV32IM words. Each word is written to the image at consecutive
//   word addresses starting at BASE_ADDR. When the program ends, the
//   loop-forever word 0x0000006f is appended.
//
//   Optional feature macro: TB_ENC_MEXT_EN. When defined, REG-class MUL..REMU
//   (ordinals 33..40) are encoded. Otherwise they are treated as illegal pairs.
//
//   Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both high. req_ready depends only on registered state, so
//   the requester may hold req_valid high across several cycles.
//
// Ports
//   clk, rstn                   clock, asynchronous active-low reset
//   req_valid / req_ready       request handshake
//   req_class, req_funct        instruction class and function ordinal
//   req_rd, req_rs1, req_rs2    register fields (rs1 carries zimm for CSRR*I)
//   req_imm                     immediate or CSR address
//   req_last                    request ends the program
//   mem_we, mem_addr, mem_wdata registered one-cycle image write
//   count                       instructions written, excluding the terminator
//   err                         sticky illegal class/funct flag
//   done                        terminator written; idle until reset
//   dbg_state                   current FSM state (RUN=0, TERM=1, DONE=2)
// ---------------------------------------------------------------------------
module tb_inst_encoder #(
    parameter int          DEPTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_class,
    input  logic [5:0]             req_funct,
    input  logic [4:0]             req_rd,
    input  logic [4:0]             req_rs1,
    input  logic [4:0]             req_rs2,
    input  logic [31:0]            req_imm,
    input  logic                   req_last,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err,
    output logic                   done,
    output logic [1:0]             dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);
    localparam logic [31:0] TERM_WORD = 32'h0000006f;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_TERM = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] CL_IMM    = 4'd0;
    localparam logic [3:0] CL_REG    = 4'd1;
    localparam logic [3:0] CL_BRANCH = 4'd2;
    localparam logic [3:0] CL_LOAD   = 4'd3;
    localparam logic [3:0] CL_STORE  = 4'd4;
    localparam logic [3:0] CL_SYS    = 4'd5;
    localparam logic [3:0] CL_JAL    = 4'd6;
    localparam logic [3:0] CL_JALR   = 4'd7;
    localparam logic [3:0] CL_LUI    = 4'd8;
    localparam logic [3:0] CL_AUIPC  = 4'd9;
    localparam logic [3:0] CL_FENCE  = 4'd10;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    // Pending stage: holds the word accepted on the previous edge.
    logic          pend_we_q, pend_we_d;
    logic          pend_term_q, pend_term_d;
    logic [31:0]   pend_addr_q, pend_addr_d;
    logic [31:0]   pend_word_q, pend_word_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          term_out_q, term_out_d;

    logic [2:0]    f3;
    logic          enc_legal;
    logic [31:0]   enc_word;
    logic          accept;
    logic [31:0]   slot_addr;

    assign req_ready = (state_q == ST_RUN) && (count_q < LAST_SLOT);
    assign accept    = req_valid && req_ready;
    assign slot_addr = BASE_ADDR + 32'({count_q, 2'b00});

    // funct3 by ordinal, shared by every class that has one.
    always_comb begin
        f3 = 3'b000;
        case (req_funct)
            6'd7, 6'd16, 6'd20, 6'd27, 6'd31, 6'd34, 6'd42:        f3 = 3'b001;
            6'd2, 6'd11, 6'd29, 6'd32, 6'd35, 6'd44:               f3 = 3'b010;
            6'd3, 6'd12, 6'd36, 6'd46:                             f3 = 3'b011;
            6'd4, 6'd13, 6'd21, 6'd26, 6'd37:                      f3 = 3'b100;
            6'd8, 6'd9, 6'd17, 6'd18, 6'd23, 6'd28, 6'd38, 6'd43:  f3 = 3'b101;
            6'd5, 6'd14, 6'd22, 6'd39, 6'd45:                      f3 = 3'b110;
            6'd6, 6'd15, 6'd24, 6'd40, 6'd47:                      f3 = 3'b111;
            default:                                               f3 = 3'b000;
        endcase
    end

    always_comb begin
        enc_legal = 1'b0;
        enc_word  = 32'h0;
        case (req_class)
            CL_IMM: if (req_funct >= 6'd10 && req_funct <= 6'd18) begin
                enc_legal = 1'b1;
                // Shift-immediates carry a 5-bit shamt; SRAI marks bit 30.
                if (req_funct >= 6'd16)
                    enc_word = {1'b0, (req_funct == 6'd18), 5'b0, req_imm[4:0],
                                req_rs1, f3, req_rd, OP_IMM};
                else
                    enc_word = {req_imm[11:0], req_rs1, f3, req_rd, OP_IMM};
            end
            CL_REG: if (req_funct <= 6'd9) begin
                enc_legal = 1'b1;
                enc_word  = {1'b0, (req_funct == 6'd1 || req_funct == 6'd9), 5'b0,
                             req_rs2, req_rs1, f3, req_rd, OP_REG};
            end
`ifdef TB_ENC_MEXT_EN
            else if (req_funct >= 6'd33 && req_funct <= 6'd40) begin
                enc_legal = 1'b1;
                enc_word  = {7'b0000001, req_rs2, req_rs1, f3, req_rd, OP_REG};
            end
`endif
            CL_BRANCH: if (req_funct >= 6'd19 && req_funct <= 6'd24) begin
                enc_legal = 1'b1;
                enc_word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, f3,
                             req_imm[4:1], req_imm[11], OP_BRANCH};
            end
            CL_LOAD: if (req_funct >= 6'd25 && req_funct <= 6'd29) begin
                enc_legal = 1'b1;
                enc_word  = {req_imm[11:0], req_rs1, f3, req_rd, OP_LOAD};
            end
            CL_STORE: if (req_funct >= 6'd30 && req_funct <= 6'd32) begin
                enc_legal = 1'b1;
                enc_word  = {req_imm[11:5], req_rs2, req_rs1, f3, req_imm[4:0], OP_STORE};
            end
            CL_SYS: if (req_funct == 6'd41) begin
                enc_legal = 1'b1;
                enc_word  = 32'h00100073;
            end else if (req_funct >= 6'd42 && req_funct <= 6'd47) begin
                enc_legal = 1'b1;
                enc_word  = {req_imm[11:0], req_rs1, f3, req_rd, OP_SYS};
            end
            CL_JAL: if (req_funct == 6'd50) begin
                enc_legal = 1'b1;
                enc_word  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                             req_rd, OP_JAL};
            end
            CL_JALR: if (req_funct == 6'd50) begin
                enc_legal = 1'b1;
                enc_word  = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
            end
            CL_LUI: if (req_funct == 6'd50) begin
                enc_legal = 1'b1;
                enc_word  = {req_imm[31:12], req_rd, OP_LUI};
            end
            CL_AUIPC: if (req_funct == 6'd50) begin
                enc_legal = 1'b1;
                enc_word  = {req_imm[31:12], req_rd, OP_AUIPC};
            end
            CL_FENCE: if (req_funct == 6'd48) begin
                enc_legal = 1'b1;
                enc_word  = 32'h0ff0000f;
            end else if (req_funct == 6'd49) begin
                enc_legal = 1'b1;
                enc_word  = 32'h0000100f;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        err_d       = err_q;
        done_d      = done_q || term_out_q;
        pend_we_d   = 1'b0;
        pend_term_d = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_word_d = pend_word_q;
        mem_we_d    = pend_we_q;
        mem_addr_d  = pend_we_q ? pend_addr_q : mem_addr_q;
        mem_wdata_d = pend_we_q ? pend_word_q : mem_wdata_q;
        term_out_d  = pend_we_q && pend_term_q;
        case (state_q)
            ST_RUN: if (accept) begin
                if (enc_legal) begin
                    // count advances at acceptance so req_ready already
                    // reflects the slot taken by the word still in flight.
                    pend_we_d   = 1'b1;
                    pend_addr_d = slot_addr;
                    pend_word_d = enc_word;
                    count_d     = count_q + 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                if (req_last || count_d == LAST_SLOT)
                    state_d = ST_TERM;
            end
            ST_TERM: begin
                pend_we_d   = 1'b1;
                pend_term_d = 1'b1;
                pend_addr_d = slot_addr;
                pend_word_d = TERM_WORD;
                state_d     = ST_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_RUN;
            count_q     <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            pend_we_q   <= 1'b0;
            pend_term_q <= 1'b0;
            pend_addr_q <= BASE_ADDR;
            pend_word_q <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'h0;
            term_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            err_q       <= err_d;
            done_q      <= done_d;
            pend_we_q   <= pend_we_d;
            pend_term_q <= pend_term_d;
            pend_addr_q <= pend_addr_d;
            pend_word_q <= pend_word_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            term_out_q  <= term_out_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign err       = err_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tb_inst_encoder.sv
// ---------------------------------------------------------------------------
// tb_tb_inst_encoder
//   Bench for tb_inst_encoder. Instance "a" uses DEPTH=32 and instance "b"
//   uses DEPTH=4; both use BASE_ADDR=0. A reference model built from
//   instruction-format arithmetic predicts each image write. Monitors compare
//   every write against an expected queue. Directed steps check the exact
//   words, timing, error handling and reset behaviour.
// ---------------------------------------------------------------------------
module tb_tb_inst_encoder;

    localparam logic [31:0] BASE    = 32'h0;
    localparam int          DEPTH_A = 32;
    localparam logic [31:0] TERM    = 32'h0000006f;
`ifdef TB_ENC_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;

    logic        req_valid = 1'b0, req_ready, req_last = 1'b0;
    logic [3:0]  req_class = '0;
    logic [5:0]  req_funct = '0;
    logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        mem_we, err, done;
    logic [31:0] mem_addr, mem_wdata;
    logic [5:0]  count;
    logic [1:0]  dbg_state;

    logic        b_req_valid = 1'b0, b_req_ready;
    logic [4:0]  b_req_rd = '0;
    logic [31:0] b_req_imm = '0;
    logic        b_mem_we, b_err, b_done;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [2:0]  b_count;
    logic [1:0]  b_dbg_state;

    tb_inst_encoder #(.DEPTH(DEPTH_A), .BASE_ADDR(BASE)) u_a (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class), .req_funct(req_funct), .req_rd(req_rd),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_last(req_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .err(err), .done(done), .dbg_state(dbg_state)
    );

    tb_inst_encoder #(.DEPTH(4), .BASE_ADDR(BASE)) u_b (
        .clk(clk), .rstn(rstn), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_class(4'd0), .req_funct(6'd10), .req_rd(b_req_rd),
        .req_rs1(5'd0), .req_rs2(5'd0), .req_imm(b_req_imm), .req_last(1'b0),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .count(b_count), .err(b_err), .done(b_done), .dbg_state(b_dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] b_exp_q[$];

    // Reference model state for instance a.
    int mcount = 0;
    bit merr   = 1'b0;
    bit mterm  = 1'b0;

    // funct3 per ordinal 0..50.
    int f3_tab [0:50] = '{0,0,2,3,4,6,7,1,5,5,  0,2,3,4,6,7,1,5,5,
                          0,1,4,6,5,7,  0,4,1,5,2,  0,1,2,
                          0,1,2,3,4,5,6,7,  0,1,5,2,6,3,7,  0,0,0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_legal(input int cls, input int fn);
        case (cls)
            0:       return fn >= 10 && fn <= 18;
            1:       return fn <= 9 || (MEXT && fn >= 33 && fn <= 40);
            2:       return fn >= 19 && fn <= 24;
            3:       return fn >= 25 && fn <= 29;
            4:       return fn >= 30 && fn <= 32;
            5:       return fn >= 41 && fn <= 47;
            6, 7, 8, 9: return fn == 50;
            10:      return fn == 48 || fn == 49;
            default: return 1'b0;
        endcase
    endfunction

    // Builds the word by placing each field at its bit position.
    function automatic logic [31:0] model_word(input int cls, input int fn, input int rd,
                                               input int rs1, input int rs2,
                                               input logic [31:0] imm);
        logic [31:0] d, s1, s2, f3, w;
        d = 32'(rd) << 7;  s1 = 32'(rs1) << 15;  s2 = 32'(rs2) << 20;
        f3 = 32'(f3_tab[fn]) << 12;
        w = 32'h0;
        case (cls)
            0: begin
                w = 32'h13 | d | f3 | s1;
                if (fn >= 16) w = w | ((imm % 32) << 20) | ((fn == 18) ? 32'h4000_0000 : 32'h0);
                else          w = w | ((imm & 32'hfff) << 20);
            end
            1: begin
                w = 32'h33 | d | f3 | s1 | s2;
                if (fn >= 33) w = w | 32'h0200_0000;
                if (fn == 1 || fn == 9) w = w | 32'h4000_0000;
            end
            2: w = 32'h63 | f3 | s1 | s2 | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25)
                   | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7);
            3: w = 32'h03 | d | f3 | s1 | ((imm & 32'hfff) << 20);
            4: w = 32'h23 | ((imm & 31) << 7) | f3 | s1 | s2 | (((imm >> 5) & 127) << 25);
            5: w = (fn == 41) ? 32'h00100073 : (32'h73 | d | f3 | s1 | ((imm & 32'hfff) << 20));
            6: w = 32'h6f | d | (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12);
            7: w = 32'h67 | d | s1 | ((imm & 32'hfff) << 20);
            8: w = 32'h37 | d | (imm & 32'hfffff000);
            9: w = 32'h17 | d | (imm & 32'hfffff000);
            10: w = (fn == 48) ? 32'h0ff0000f : 32'h0000100f;
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Monitors: every image write must match the head of its expected queue.
    always @(negedge clk) begin
        if (rstn && mem_we) begin
            logic [63:0] e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = 'x;
            chk("a_write", {mem_addr, mem_wdata}, e);
        end
    end

    always @(negedge clk) begin
        if (rstn && b_mem_we) begin
            logic [63:0] e;
            if (b_exp_q.size() > 0) e = b_exp_q.pop_front();
            else                    e = 'x;
            chk("b_write", {b_mem_addr, b_mem_wdata}, e);
        end
    end

    task automatic check_reset_values();
        chk("rst_ready", req_ready, 1);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, BASE);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_count", count, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);
        chk("rst_b_count", b_count, 0);
    endtask

    task automatic model_clear();
        exp_q.delete();
        b_exp_q.delete();
        mcount = 0;
        merr   = 1'b0;
        mterm  = 1'b0;
    endtask

    // Leaves the bench 1 ns after a rising edge with reset released.
    task automatic do_reset();
        req_valid   = 1'b0;
        b_req_valid = 1'b0;
        #2;
        rstn = 1'b0;
        model_clear();
        #1;
        check_reset_values();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Presents one request, waits (bounded) for the transfer, then updates the model.
    task automatic send(input int cls, input int fn, input int rd, input int rs1,
                        input int rs2, input logic [31:0] imm, input bit last);
        logic got;
        got = 1'b0;
        req_valid = 1'b1;
        req_class = 4'(cls);  req_funct = 6'(fn);
        req_rd = 5'(rd);  req_rs1 = 5'(rs1);  req_rs2 = 5'(rs2);
        req_imm = imm;  req_last = last;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("ready_timeout", got, 1);
        if (got) begin
            if (model_legal(cls, fn)) begin
                exp_q.push_back({BASE + 32'(mcount * 4), model_word(cls, fn, rd, rs1, rs2, imm)});
                mcount++;
            end else begin
                merr = 1'b1;
            end
            if (last || mcount == DEPTH_A - 1) begin
                mterm = 1'b1;
                exp_q.push_back({BASE + 32'(mcount * 4), TERM});
            end
        end
    endtask

    task automatic wait_done();
        for (int c = 0; c < 10 && !done; c++) @(negedge clk);
        chk("done_timeout", done, 1);
    endtask

    initial begin
        int cls, fn, acc, k;
        bit will;
        logic [31:0] b_w;
        bit exp_mul_err;

        // ADDI: latency, word and address.
        do_reset();
        send(0, 10, 1, 0, 0, 32'd5, 1'b0);
        @(negedge clk);
        chk("addi_lat_we", mem_we, 0);
        chk("addi_count", count, 1);
        @(negedge clk);
        chk("addi_we", mem_we, 1);
        chk("addi_word", mem_wdata, 32'h00500093);
        chk("addi_addr", mem_addr, 32'h0);
        @(posedge clk); #1;

        // BRANCH with ADD funct is illegal: err, no write, count unchanged.
        send(2, 0, 1, 2, 3, 32'd16, 1'b0);
        @(negedge clk);
        chk("ill_we0", mem_we, 0);
        chk("ill_err", err, 1);
        chk("ill_count", count, 1);
        @(negedge clk);
        chk("ill_we1", mem_we, 0);
        @(posedge clk); #1;
        send(0, 10, 2, 0, 0, 32'd7, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("after_ill_addr", mem_addr, 32'h4);
        chk("after_ill_word", mem_wdata, 32'h00700113);

        // BEQ with negative offset.
        do_reset();
        send(2, 19, 0, 1, 2, 32'hFFFF_FFF8, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("beq_word", mem_wdata, 32'hFE208CE3);

        // REG/MUL: encoded only with the M extension enabled.
        @(posedge clk); #1;
        send(1, 33, 5, 6, 7, 32'd0, 1'b0);
        exp_mul_err = !MEXT;
        @(negedge clk); @(negedge clk);
        chk("mul_we", mem_we, !exp_mul_err);
        chk("mul_err", err, exp_mul_err);
        chk("mul_count", count, exp_mul_err ? 1 : 2);

        // SUB then CSRRS with last: two words, terminator, then done.
        do_reset();
        send(1, 1, 3, 1, 2, 32'd0, 1'b0);
        send(5, 44, 10, 0, 0, 32'hC00, 1'b1);
        @(negedge clk);
        chk("sub_word", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h0, 32'h402081b3});
        @(negedge clk);
        chk("csrrs_word", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h4, 32'hC0002573});
        @(negedge clk);
        chk("term_word", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h8, TERM});
        chk("done_before", done, 0);
        @(negedge clk);
        chk("done_we", mem_we, 0);
        chk("done_set", done, 1);
        chk("done_ready", req_ready, 0);

        // Reset in the middle of a back-to-back stream drops in-flight writes.
        do_reset();
        send(0, 10, 1, 0, 0, 32'd1, 1'b0);
        send(0, 10, 2, 0, 0, 32'd2, 1'b0);
        send(0, 10, 3, 0, 0, 32'd3, 1'b0);
        #1;
        rstn = 1'b0;
        model_clear();
        #1;
        check_reset_values();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_rst_we0", mem_we, 0);
        @(negedge clk);
        chk("mid_rst_we1", mem_we, 0);
        chk("mid_rst_count", count, 0);

        // Random programs against the reference model.
        for (int p = 0; p < 4; p++) begin
            do_reset();
            for (int i = 0; i < 45 && !mterm; i++) begin
                cls = $urandom_range(0, 11);
                if ($urandom_range(0, 7) == 0) fn = $urandom_range(0, 63);
                else begin
                    case (cls)
                        0:  fn = $urandom_range(10, 18);
                        1:  fn = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 9) : $urandom_range(33, 40);
                        2:  fn = $urandom_range(19, 24);
                        3:  fn = $urandom_range(25, 29);
                        4:  fn = $urandom_range(30, 32);
                        5:  fn = $urandom_range(41, 47);
                        10: fn = $urandom_range(48, 49);
                        11: fn = $urandom_range(0, 50);
                        default: fn = 50;
                    endcase
                end
                send(cls, fn, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom, ($urandom_range(0, 15) == 0));
            end
            if (!mterm) send(0, 10, 1, 1, 0, $urandom, 1'b1);
            wait_done();
            chk("rnd_count", count, mcount);
            chk("rnd_err", err, merr);
            chk("rnd_ready", req_ready, 0);
            chk("rnd_pending", exp_q.size(), 0);
        end

        // DEPTH=4: five requests offered back to back, three fit.
        do_reset();
        acc = 0;
        k = 0;
        b_req_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            b_req_rd  = 5'(k + 1);
            b_req_imm = 32'(k + 1);
            @(negedge clk);
            will = b_req_ready && (k < 5);
            @(posedge clk);
            #1;
            if (will) begin
                b_w = model_word(0, 10, k + 1, 0, 0, 32'(k + 1));
                b_exp_q.push_back({BASE + 32'(k * 4), b_w});
                k++;
                acc++;
                if (k == 3) b_exp_q.push_back({BASE + 32'h0C, TERM});
            end
            if (k == 5) b_req_valid = 1'b0;
        end
        b_req_valid = 1'b0;
        chk("b_accepts", acc, 3);
        chk("b_count", b_count, 3);
        chk("b_done", b_done, 1);
        chk("b_ready", b_req_ready, 0);
        chk("b_err", b_err, 0);
        chk("b_pending", b_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
